// File: rtl/instruction_decode_unit_pkg.sv
// Shared constants for the decode stage: opcode values, instruction
// field positions and default widths. Also holds the helper that
// decides whether an opcode reads rt as a source operand.
package instruction_decode_unit_pkg;

   localparam int NB_DATA_DEF     = 32;
   localparam int NB_REG_ADDR_DEF = 5;

   localparam logic [5:0] OP_RTYPE        = 6'b000000;
   localparam logic [5:0] OP_BEQ          = 6'b000100;
   localparam logic [5:0] OP_BNE          = 6'b000101;
   localparam logic [5:0] OP_LW           = 6'b100011;
   localparam logic [5:0] OP_SW           = 6'b101011;
   localparam logic [2:0] OP_STORE_PREFIX = 3'b101;

   localparam int OPCODE_LSB = 26;
   localparam int OPCODE_W   = 6;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int SHAMT_W    = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int FUNCT_W    = 6;
   localparam int IMM_LSB    = 0;
   localparam int IMM_W      = 16;

   // R-type, branches and stores read rt; everything else only reads rs.
   function automatic logic is_rt_source(input logic [OPCODE_W-1:0] opcode);
      return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
             (opcode[5:3] == OP_STORE_PREFIX);
   endfunction

endpackage

// File: rtl/instruction_decode_unit_register_file.sv
// 32-entry register file for the decode stage.
// Ports: i_clock/i_reset_n, one write port (i_we, i_wa, i_wd),
// two combinational read ports (i_ra0/o_rd0, i_ra1/o_rd1).
// r0 is hardwired to zero; a same-cycle write to a nonzero read
// address is forwarded to that read port.
module register_file #(
   parameter int NB_DATA     = 32,
   parameter int NB_REG_ADDR = 5
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_we,
   input  logic [NB_REG_ADDR-1:0] i_wa,
   input  logic [NB_DATA-1:0]     i_wd,
   input  logic [NB_REG_ADDR-1:0] i_ra0,
   input  logic [NB_REG_ADDR-1:0] i_ra1,
   output logic [NB_DATA-1:0]     o_rd0,
   output logic [NB_DATA-1:0]     o_rd1
);

   localparam int N_REGS = 2 ** NB_REG_ADDR;

   logic [NB_DATA-1:0] mem_q [N_REGS];
   logic [NB_DATA-1:0] mem_d [N_REGS];
   logic               wr_en;

   assign wr_en = i_we && (i_wa != '0);

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[i_wa] = i_wd;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) mem_q <= '{default: '0};
      else            mem_q <= mem_d;
   end

   always_comb begin
      o_rd0 = '0;
      if (i_ra0 != '0) o_rd0 = (wr_en && (i_wa == i_ra0)) ? i_wd : mem_q[i_ra0];
   end

   always_comb begin
      o_rd1 = '0;
      if (i_ra1 != '0) o_rd1 = (wr_en && (i_wa == i_ra1)) ? i_wd : mem_q[i_ra1];
   end

endmodule

// File: rtl/instruction_decode_unit.sv
// Decode stage: splits the fetched instruction into fields, reads
// operands from the register file, detects load-use hazards and
// registers the result into the ID/EX latch (one cycle latency).
// Inputs: instruction and pc+1 from fetch, flush, write-back port,
// EX-stage load info. Outputs: combinational o_stall to fetch and
// the registered ID/EX fields (o_valid, opcode/funct/rs/rt/rd/shamt,
// operand data, sign-extended immediate, pc+1).
module instruction_decode_unit
   import instruction_decode_unit_pkg::*;
#(
   parameter int NB_DATA     = NB_DATA_DEF,
   parameter int NB_REG_ADDR = NB_REG_ADDR_DEF,
   parameter int NB_PC       = 5
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic [NB_DATA-1:0]     i_instruction,
   input  logic [NB_PC-1:0]       i_pc_inc,
   input  logic                   i_flush,
   input  logic                   i_wb_write_enable,
   input  logic [NB_REG_ADDR-1:0] i_wb_addr,
   input  logic [NB_DATA-1:0]     i_wb_data,
   input  logic                   i_ex_mem_read,
   input  logic [NB_REG_ADDR-1:0] i_ex_rt,
   output logic                   o_stall,
   output logic                   o_valid,
   output logic [OPCODE_W-1:0]    o_opcode,
   output logic [FUNCT_W-1:0]     o_funct,
   output logic [NB_REG_ADDR-1:0] o_rs,
   output logic [NB_REG_ADDR-1:0] o_rt,
   output logic [NB_REG_ADDR-1:0] o_rd,
   output logic [SHAMT_W-1:0]     o_shamt,
   output logic [NB_DATA-1:0]     o_rs_data,
   output logic [NB_DATA-1:0]     o_rt_data,
   output logic [NB_DATA-1:0]     o_imm_ext,
   output logic [NB_PC-1:0]       o_pc_inc
);

   logic [OPCODE_W-1:0]    opcode;
   logic [FUNCT_W-1:0]     funct;
   logic [NB_REG_ADDR-1:0] rs, rt, rd;
   logic [SHAMT_W-1:0]     shamt;
   logic [IMM_W-1:0]       imm;
   logic [NB_DATA-1:0]     rs_rd, rt_rd;
   logic                   load_use;

   assign opcode = i_instruction[OPCODE_LSB +: OPCODE_W];
   assign rs     = i_instruction[RS_LSB +: NB_REG_ADDR];
   assign rt     = i_instruction[RT_LSB +: NB_REG_ADDR];
   assign rd     = i_instruction[RD_LSB +: NB_REG_ADDR];
   assign shamt  = i_instruction[SHAMT_LSB +: SHAMT_W];
   assign funct  = i_instruction[FUNCT_LSB +: FUNCT_W];
   assign imm    = i_instruction[IMM_LSB +: IMM_W];

   register_file #(
      .NB_DATA     (NB_DATA),
      .NB_REG_ADDR (NB_REG_ADDR)
   ) u_register_file (
      .i_clock (i_clock),
      .i_reset_n (i_reset_n),
      .i_we    (i_wb_write_enable),
      .i_wa    (i_wb_addr),
      .i_wd    (i_wb_data),
      .i_ra0   (rs),
      .i_ra1   (rt),
      .o_rd0   (rs_rd),
      .o_rd1   (rt_rd)
   );

   assign load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                     ((i_ex_rt == rs) || (is_rt_source(opcode) && (i_ex_rt == rt)));

   // Flush squashes the instruction anyway, so holding fetch would be wrong.
   assign o_stall = i_reset_n && !i_flush && load_use;

   logic                   valid_d,   valid_q;
   logic [OPCODE_W-1:0]    opcode_d,  opcode_q;
   logic [FUNCT_W-1:0]     funct_d,   funct_q;
   logic [NB_REG_ADDR-1:0] rs_d,      rs_q;
   logic [NB_REG_ADDR-1:0] rt_d,      rt_q;
   logic [NB_REG_ADDR-1:0] rd_d,      rd_q;
   logic [SHAMT_W-1:0]     shamt_d,   shamt_q;
   logic [NB_DATA-1:0]     rs_data_d, rs_data_q;
   logic [NB_DATA-1:0]     rt_data_d, rt_data_q;
   logic [NB_DATA-1:0]     imm_ext_d, imm_ext_q;
   logic [NB_PC-1:0]       pc_inc_d,  pc_inc_q;

   // Bubble is all-zero; a real instruction loads every field.
   always_comb begin
      valid_d   = 1'b0;
      opcode_d  = '0;
      funct_d   = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      shamt_d   = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_ext_d = '0;
      pc_inc_d  = '0;
      if (!i_flush && !load_use) begin
         valid_d   = 1'b1;
         opcode_d  = opcode;
         funct_d   = funct;
         rs_d      = rs;
         rt_d      = rt;
         rd_d      = rd;
         shamt_d   = shamt;
         rs_data_d = rs_rd;
         rt_data_d = rt_rd;
         imm_ext_d = {{(NB_DATA-IMM_W){imm[IMM_W-1]}}, imm};
         pc_inc_d  = i_pc_inc;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_q   <= 1'b0;
         opcode_q  <= '0;
         funct_q   <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         shamt_q   <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_ext_q <= '0;
         pc_inc_q  <= '0;
      end else begin
         valid_q   <= valid_d;
         opcode_q  <= opcode_d;
         funct_q   <= funct_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         shamt_q   <= shamt_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_ext_q <= imm_ext_d;
         pc_inc_q  <= pc_inc_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_opcode  = opcode_q;
   assign o_funct   = funct_q;
   assign o_rs      = rs_q;
   assign o_rt      = rt_q;
   assign o_rd      = rd_q;
   assign o_shamt   = shamt_q;
   assign o_rs_data = rs_data_q;
   assign o_rt_data = rt_data_q;
   assign o_imm_ext = imm_ext_q;
   assign o_pc_inc  = pc_inc_q;

endmodule

// File: tb/tb_instruction_decode_unit.sv
module tb_instruction_decode_unit;

   logic        i_clock;
   logic        i_reset_n;
   logic [31:0] i_instruction;
   logic [4:0]  i_pc_inc;
   logic        i_flush;
   logic        i_wb_write_enable;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        i_ex_mem_read;
   logic [4:0]  i_ex_rt;
   logic        o_stall;
   logic        o_valid;
   logic [5:0]  o_opcode;
   logic [5:0]  o_funct;
   logic [4:0]  o_rs, o_rt, o_rd;
   logic [4:0]  o_shamt;
   logic [31:0] o_rs_data, o_rt_data, o_imm_ext;
   logic [4:0]  o_pc_inc;

   instruction_decode_unit dut (
      .i_clock           (i_clock),
      .i_reset_n         (i_reset_n),
      .i_instruction     (i_instruction),
      .i_pc_inc          (i_pc_inc),
      .i_flush           (i_flush),
      .i_wb_write_enable (i_wb_write_enable),
      .i_wb_addr         (i_wb_addr),
      .i_wb_data         (i_wb_data),
      .i_ex_mem_read     (i_ex_mem_read),
      .i_ex_rt           (i_ex_rt),
      .o_stall           (o_stall),
      .o_valid           (o_valid),
      .o_opcode          (o_opcode),
      .o_funct           (o_funct),
      .o_rs              (o_rs),
      .o_rt              (o_rt),
      .o_rd              (o_rd),
      .o_shamt           (o_shamt),
      .o_rs_data         (o_rs_data),
      .o_rt_data         (o_rt_data),
      .o_imm_ext         (o_imm_ext),
      .o_pc_inc          (o_pc_inc)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference register file contents (architectural view).
   logic [31:0] rf_m [32];

   localparam logic [31:0] ADD_8_9_10 = 32'h012A4020;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_fields"}, {o_opcode, o_funct, o_rs, o_rt, o_rd, o_shamt, 1'b0}, 32'd0);
      chk({tag, "_rs_data"}, o_rs_data, 32'd0);
      chk({tag, "_rt_data"}, o_rt_data, 32'd0);
      chk({tag, "_imm"}, o_imm_ext, 32'd0);
      chk({tag, "_pc"}, 32'(o_pc_inc), 32'd0);
      chk({tag, "_stall"}, 32'(o_stall), 32'd0);
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0) return 32'd0;
      if (we && wa == a) return wd;
      return rf_m[a];
   endfunction

   // One decode cycle: drive inputs, check stall, clock, check the latch.
   task automatic step(input logic [31:0] instr, input logic [4:0] pc, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mr, input logic [4:0] xrt);
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic        rt_src, haz, bubble;
      logic [31:0] e_rs, e_rt, e_imm;
      i_instruction     = instr;
      i_pc_inc          = pc;
      i_flush           = fl;
      i_wb_write_enable = we;
      i_wb_addr         = wa;
      i_wb_data         = wd;
      i_ex_mem_read     = mr;
      i_ex_rt           = xrt;
      #1;
      op = instr[31:26];
      rs = instr[25:21];
      rt = instr[20:16];
      rt_src = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op[5:3] == 3'b101);
      haz    = mr && (xrt != 0) && ((xrt == rs) || (rt_src && xrt == rt));
      bubble = fl || haz;
      chk("stall", 32'(o_stall), 32'(haz && !fl));
      e_rs  = model_read(rs, we, wa, wd);
      e_rt  = model_read(rt, we, wa, wd);
      e_imm = $signed(instr[15:0]);
      @(posedge i_clock);
      #1;
      if (we && wa != 0) rf_m[wa] = wd;
      chk("valid", 32'(o_valid), 32'(!bubble));
      chk("opcode", 32'(o_opcode), bubble ? 32'd0 : 32'(op));
      chk("funct", 32'(o_funct), bubble ? 32'd0 : 32'(instr[5:0]));
      chk("rs_rt_rd", {17'd0, o_rs, o_rt, o_rd},
          bubble ? 32'd0 : {17'd0, rs, rt, instr[15:11]});
      chk("shamt", 32'(o_shamt), bubble ? 32'd0 : 32'(instr[10:6]));
      chk("rs_data", o_rs_data, bubble ? 32'd0 : e_rs);
      chk("rt_data", o_rt_data, bubble ? 32'd0 : e_rt);
      chk("imm_ext", o_imm_ext, bubble ? 32'd0 : e_imm);
      chk("pc_inc", 32'(o_pc_inc), bubble ? 32'd0 : 32'(pc));
   endtask

   logic [5:0] op_tbl [8];

   initial begin
      op_tbl = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h28, 6'h0D};
      foreach (rf_m[i]) rf_m[i] = 32'd0;

      // Reset held with a hazard pattern on the inputs: stall must stay low.
      i_reset_n         = 1'b0;
      i_instruction     = ADD_8_9_10;
      i_pc_inc          = 5'd3;
      i_flush           = 1'b0;
      i_wb_write_enable = 1'b0;
      i_wb_addr         = 5'd0;
      i_wb_data         = 32'd0;
      i_ex_mem_read     = 1'b1;
      i_ex_rt           = 5'd9;
      repeat (2) @(posedge i_clock);
      #1;
      chk_all_zero("reset");
      #3 i_reset_n = 1'b1;
      @(posedge i_clock);
      #1;

      // Plain decode after reset: operands read zero.
      step(ADD_8_9_10, 5'd1, 0, 0, 5'd0, 32'd0, 0, 5'd0);
      // Write r9, then read it back; then bypass r10.
      step(32'd0, 5'd2, 0, 1, 5'd9, 32'h0000_00AA, 0, 5'd0);
      step(ADD_8_9_10, 5'd3, 0, 0, 5'd0, 32'd0, 0, 5'd0);
      step(ADD_8_9_10, 5'd4, 0, 1, 5'd10, 32'h0000_0055, 0, 5'd0);
      // r0 write ignored, r0 read is zero (also same-cycle).
      step(32'd0, 5'd5, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0);
      step(32'h000A4020, 5'd6, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0);
      // Load-use on rs.
      step(ADD_8_9_10, 5'd7, 0, 0, 5'd0, 32'd0, 1, 5'd9);
      // addi rt=10 with EX load to r10: rt not a source, no stall.
      step(32'h202A0005, 5'd8, 0, 0, 5'd0, 32'd0, 1, 5'd10);
      // sw with EX load to its rt: stall.
      step(32'hAC2A0010, 5'd9, 0, 0, 5'd0, 32'd0, 1, 5'd10);
      // Flush beats stall.
      step(ADD_8_9_10, 5'd10, 1, 0, 5'd0, 32'd0, 1, 5'd9);
      // EX load to r0 never stalls.
      step(32'h00004020, 5'd11, 0, 0, 5'd0, 32'd0, 1, 5'd0);
      // Sign extension boundaries.
      step(32'h202A8004, 5'd12, 0, 0, 5'd0, 32'd0, 0, 5'd0);
      step(32'h202A7FFF, 5'd13, 0, 0, 5'd0, 32'd0, 0, 5'd0);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] instr;
         instr = {op_tbl[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 16'($urandom)};
         step(instr, 5'($urandom), ($urandom_range(0, 9) == 0),
              1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)));
      end

      // Reset pulsed mid-stream between edges: latch clears at once.
      step(ADD_8_9_10, 5'd21, 0, 1, 5'd9, 32'h1234_5678, 0, 5'd0);
      i_ex_mem_read = 1'b1;
      i_ex_rt       = 5'd9;
      #2 i_reset_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      foreach (rf_m[i]) rf_m[i] = 32'd0;
      #2 i_reset_n = 1'b1;
      // First edge after release loads normally, old r9 content is gone.
      step(ADD_8_9_10, 5'd22, 0, 0, 5'd0, 32'd0, 0, 5'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_decode_unit.md
Name: instruction_decode_unit

Overview:
- Decode stage directly downstream of instruction fetch. Consumes the latched 32-bit instruction and pc+1 from fetch.
- Splits the instruction into fields and sign-extends the immediate.
- Reads operands from an internal 32x32 register file. The register file takes write-back from later stages.
- Detects load-use hazards, and drives the stall request back to fetch. Registers everything into the ID/EX latch.

Parameters:
- NB_DATA, 32, data/instruction width.
- NB_REG_ADDR, 5, register index width.
- NB_PC, 5, pc width; must match the fetch unit's NB_ADDR.

Ports:
- i_clock  in  1  stage clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_instruction  in  NB_DATA  instruction from fetch.
- i_pc_inc  in  NB_PC  pc+1 from fetch.
- i_flush  in  1  branch taken; squash the instruction currently in decode.
- i_wb_write_enable  in  1  write-back strobe.
- i_wb_addr  in  NB_REG_ADDR  write-back destination.
- i_wb_data  in  NB_DATA  write-back value.
- i_ex_mem_read  in  1  instruction in EX is a load.
- i_ex_rt  in  NB_REG_ADDR  destination of that load.
- o_stall  out  1  hold pc and the fetch latch (combinational).
- o_valid  out  1  ID/EX latch holds a real instruction.
- o_opcode  out  6  instr[31:26].
- o_funct  out  6  instr[5:0].
- o_rs, o_rt, o_rd  out  NB_REG_ADDR each  instr[25:21], [20:16], [15:11].
- o_shamt  out  5  instr[10:6].
- o_rs_data, o_rt_data  out  NB_DATA  operand values.
- o_imm_ext  out  NB_DATA  sign-extended instr[15:0].
- o_pc_inc  out  NB_PC  pc+1 carried forward.

Behaviour:
- Reset, while i_reset_n=0:
  - All registered outputs are 0, including o_valid=0.
  - All 32 register-file entries are 0.
  - o_stall is forced to 0.
- Latency: one cycle. Inputs present before rising edge N appear on the outputs after edge N.
- Register file:
  - Synchronous write on the rising edge when i_wb_write_enable=1 and i_wb_addr!=0.
  - Writes to r0 are ignored; reads of r0 always return 0.
  - Combinational read with internal bypass: if a same-cycle write targets a nonzero read address, the read returns i_wb_data. The bypass applies to rs and rt independently.
- rt-as-source rule: rt is a source when opcode==000000 (R-type), 000100 (beq), 000101 (bne), or opcode[5:3]==101 (stores). Otherwise only rs is a source.
- Hazard detection: o_stall=1 when all of the following hold:
  - i_ex_mem_read=1
  - i_ex_rt!=0
  - i_ex_rt==rs, or (rt is a source and i_ex_rt==rt)
- On stall: the ID/EX latch loads a bubble (o_valid=0, all other outputs 0). Fetch re-presents the same instruction the next cycle.
- On i_flush=1: the ID/EX latch loads a bubble and o_stall=0. Flush has priority over stall.
- Otherwise: the latch loads the decoded fields, o_valid=1.
- Sign extension: o_imm_ext = {16{instr[15]}, instr[15:0]}.
- o_pc_inc is passed through unmodified; no arithmetic is done on the pc in this block.
- Reset asserted mid-operation:
  - The latch clears immediately and asynchronously.
  - Register-file contents are lost.
  - The first edge after deassertion loads normally.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_STORE_PREFIX.
  - Field position/width constants.
  - NB_DATA and NB_REG_ADDR defaults.
- One sub-module, register_file: 2 read ports, 1 write port, r0 hardwired, internal bypass.
- Hazard logic, field split and the ID/EX latch stay in the top module.

Test Plan:
- Reset check: deassert reset with no write-back. Instruction 0x012A4020 (add r8,r9,r10) -> next cycle o_valid=1, o_rs=9, o_rt=10, o_rd=8, o_rs_data=0, o_rt_data=0.
- Write r9=0x0000_00AA, then decode the same add -> o_rs_data=0xAA. With a same-cycle write of r10=0x55 -> o_rt_data=0x55 via bypass.
- Write-back to r0 with data 0xFFFF_FFFF, then decode reading r0 -> o_rs_data=0.
- Load-use stall: i_ex_mem_read=1, i_ex_rt=9, instruction add r8,r9,r10 -> o_stall=1 and the next o_valid=0.
  - With i_ex_rt=10 and instruction addi (opcode 001000, rt=10) -> o_stall=0, because rt is not a source for addi.
- Flush priority: i_flush=1 together with a stall condition -> o_stall=0, next o_valid=0.
- Immediate 0x8004 -> o_imm_ext=0xFFFF_8004; immediate 0x7FFF -> 0x0000_7FFF.
- Reset pulsed mid-stream -> outputs 0 asynchronously, before the next clock edge.
